btn_event_scheduler: RTL

//  Turns N debounced button levels into a queued stream of press events (button id, short/long).

---
 rtl/btn_evt_pkg.sv | 21 ++
 rtl/btn_press_timer.sv | 40 ++++
 rtl/btn_event_scheduler.sv | 120 ++++++++++++
 3 files changed

// File: rtl/btn_evt_pkg.sv
// Shared sizing helpers for the button event scheduler.
// Timing and width derivations plus the FIFO depth legality check.
package btn_evt_pkg;

   function automatic int calc_long_cyc(input int freq_mhz, input int long_ms);
      return long_ms * 1000 * freq_mhz;
   endfunction

   function automatic int calc_cnt_w(input int long_cyc);
      return $clog2(long_cyc + 1);
   endfunction

   function automatic int calc_id_w(input int n_btn);
      return (n_btn < 2) ? 1 : $clog2(n_btn);
   endfunction

   function automatic bit fifo_depth_ok(input int depth);
      return (depth >= 2) && ((depth & (depth - 1)) == 0);
   endfunction

endpackage

// File: rtl/btn_press_timer.sv
// Per-button hold timer: arming after a low sample, saturating hold count,
// and release detection with short/long classification.
module btn_press_timer
   import btn_evt_pkg::*;
#(
   parameter int CNT_W    = 10,
   parameter int LONG_CYC = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic rel_pulse,
   output logic rel_long,
   output logic held
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LONG_CYC);

   logic             armed;
   logic [CNT_W-1:0] cnt;

   // A button already high when reset drops stays unarmed until it is seen low.
   always_ff @(posedge clk) begin
      if (rst) begin
         armed <= 1'b0;
         cnt   <= '0;
      end else begin
         if (!btn) armed <= 1'b1;
         if (!armed || !btn)
            cnt <= '0;
         else if (cnt != CNT_MAX)
            cnt <= cnt + CNT_W'(1);
      end
   end

   assign rel_pulse = armed & ~btn & (cnt != '0);
   assign rel_long  = (cnt >= CNT_MAX);
   assign held      = (cnt != '0);

endmodule

// File: rtl/btn_event_scheduler.sv
// Queues button release events (id, short/long) from N debounced buttons into
// a small FIFO drained by a valid/ready consumer; lowest index wins ties.
module btn_event_scheduler
   import btn_evt_pkg::*;
#(
   parameter  int N_BTN      = 4,
   parameter  int FREQUENCY  = 5,
   parameter  int LONG_MS    = 1000,
   parameter  int FIFO_DEPTH = 4,
   localparam int LONG_CYC   = calc_long_cyc(FREQUENCY, LONG_MS),
   localparam int CNT_W      = calc_cnt_w(LONG_CYC),
   localparam int ID_W       = calc_id_w(N_BTN)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_BTN-1:0] btn_lvl,
   input  logic            evt_ready,
   output logic            evt_valid,
   output logic [ID_W-1:0] evt_id,
   output logic            evt_long,
   output logic            overflow,
   output logic            busy
);

   localparam int AW = $clog2(FIFO_DEPTH);

   if (!fifo_depth_ok(FIFO_DEPTH)) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of 2 and >= 2");
   end

   typedef struct packed {
      logic [ID_W-1:0] id;
      logic            is_long;
   } evt_t;

   logic [N_BTN-1:0] rel_pulse, rel_long, held;
   logic [N_BTN-1:0] pend, pend_long;
   logic [N_BTN-1:0] grant, push_mask;
   logic [ID_W-1:0]  sel;
   logic             sel_vld, sel_long;
   logic             push, pop, full;

   evt_t             mem [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      count;

   for (genvar i = 0; i < N_BTN; i++) begin : g_btn
      btn_press_timer #(
         .CNT_W    (CNT_W),
         .LONG_CYC (LONG_CYC)
      ) u_timer (
         .clk       (clk),
         .rst       (rst),
         .btn       (btn_lvl[i]),
         .rel_pulse (rel_pulse[i]),
         .rel_long  (rel_long[i]),
         .held      (held[i])
      );
   end

   // Descending scan so the lowest pending index is the one left standing.
   always_comb begin
      grant    = '0;
      sel      = '0;
      sel_vld  = 1'b0;
      sel_long = 1'b0;
      for (int i = N_BTN - 1; i >= 0; i--) begin
         if (pend[i]) begin
            grant    = '0;
            grant[i] = 1'b1;
            sel      = ID_W'(i);
            sel_vld  = 1'b1;
            sel_long = pend_long[i];
         end
      end
   end

   assign evt_valid = (count != '0);
   assign full      = (count == (AW+1)'(FIFO_DEPTH));
   assign pop       = evt_valid & evt_ready;
   assign push      = sel_vld & (~full | pop);
   assign push_mask = push ? grant : '0;

   // A slot being pushed this cycle is free again, so a release on it is accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend      <= '0;
         pend_long <= '0;
         overflow  <= 1'b0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         for (int k = 0; k < FIFO_DEPTH; k++) mem[k] <= '0;
      end else begin
         for (int i = 0; i < N_BTN; i++) begin
            if (rel_pulse[i] && (!pend[i] || push_mask[i])) begin
               pend[i]      <= 1'b1;
               pend_long[i] <= rel_long[i];
            end else if (push_mask[i]) begin
               pend[i] <= 1'b0;
            end
         end
         if (|(rel_pulse & pend & ~push_mask)) overflow <= 1'b1;
         if (push) begin
            mem[wr_ptr] <= '{id: sel, is_long: sel_long};
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)
            count <= count + (AW+1)'(1);
         else if (pop && !push)
            count <= count - (AW+1)'(1);
      end
   end

   assign evt_id   = mem[rd_ptr].id;
   assign evt_long = mem[rd_ptr].is_long;
   assign busy     = (|held) | (|pend) | evt_valid;

endmodule
